// File: rtl/crc_param_faulty_memory.sv
// rtl/crc_param_faulty_memory.sv - CRC-protected word memory with read-path burst fault injection
// Optional CRC_ERR_LOG_EN adds err_count / err_last_addr error logging.
module crc_param_faulty_memory #(
    parameter int DATA_W = 8,
    parameter int CRC_W = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = 8'h07,
    parameter int ADDR_W = 4,
    parameter int DEPTH = 16,
    parameter int BURST_W = 3,
    localparam int CW = DATA_W + CRC_W,
    localparam int FA_W = $clog2(CW)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write,
    input  logic               read,
    input  logic [DATA_W-1:0]  data_in,
    input  logic [ADDR_W-1:0]  addr_in,
    input  logic [FA_W-1:0]    fault_addr,
    input  logic [BURST_W-1:0] burst_error_length,
    input  logic               fault_enable,
    output logic               mem_write_busy,
    output logic               read_busy,
    output logic               data_valid,
    output logic               error_detected,
    output logic               completed,
`ifdef CRC_ERR_LOG_EN
    output logic [DATA_W-1:0]  data_out,
    output logic [7:0]         err_count,
    output logic [ADDR_W-1:0]  err_last_addr
);
`else
    output logic [DATA_W-1:0]  data_out
);
`endif

    localparam int CNT_W = $clog2(CW);

    typedef enum logic [2:0] {
        IDLE, W_CALC, W_STORE, R_FETCH, R_CHECK, DONE
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]      mem [DEPTH];
    logic [CW-1:0]      shreg;
    logic [CW-1:0]      fault_mask;
    logic [CRC_W-1:0]   crc;
    logic [CRC_W-1:0]   crc_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  lat_data;
    logic [DATA_W-1:0]  rd_data;
    logic [ADDR_W-1:0]  lat_addr;
    logic [FA_W-1:0]    lat_fa;
    logic [BURST_W-1:0] lat_len;
    logic               lat_fe;
    logic               addr_ok;
    logic               check_last;
    logic               check_err;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        logic fb;
        fb = c[CRC_W-1] ^ b;
        return {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    assign addr_ok    = int'(lat_addr) < DEPTH;
    assign crc_nxt    = crc_step(crc, shreg[CW-1]);
    assign check_last = (state == R_CHECK) && (cnt == CNT_W'(CW - 1));
    assign check_err  = !addr_ok || (crc_nxt != '0);

    // Burst covers lat_fa .. lat_fa+lat_len; positions past the MSB simply fall off.
    always_comb begin
        fault_mask = '0;
        for (int i = 0; i < CW; i++) begin
            if (i >= int'(lat_fa) && i <= int'(lat_fa) + int'(lat_len))
                fault_mask[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state     = state;
        mem_write_busy = 1'b0;
        read_busy      = 1'b0;
        completed      = 1'b0;
        case (state)
            IDLE: begin
                if (write)
                    next_state = W_CALC;
                else if (read)
                    next_state = R_FETCH;
            end
            W_CALC: begin
                mem_write_busy = 1'b1;
                if (cnt == CNT_W'(DATA_W - 1))
                    next_state = W_STORE;
            end
            W_STORE: begin
                mem_write_busy = 1'b1;
                next_state     = DONE;
            end
            R_FETCH: begin
                read_busy  = 1'b1;
                next_state = R_CHECK;
            end
            R_CHECK: begin
                read_busy = 1'b1;
                if (check_last)
                    next_state = DONE;
            end
            DONE: begin
                completed  = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            shreg          <= '0;
            crc            <= '0;
            cnt            <= '0;
            lat_data       <= '0;
            rd_data        <= '0;
            lat_addr       <= '0;
            lat_fa         <= '0;
            lat_len        <= '0;
            lat_fe         <= 1'b0;
            data_valid     <= 1'b0;
            error_detected <= 1'b0;
            data_out       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write || read) begin
                        data_valid     <= 1'b0;
                        error_detected <= 1'b0;
                        lat_data       <= data_in;
                        lat_addr       <= addr_in;
                        lat_fa         <= fault_addr;
                        lat_len        <= burst_error_length;
                        lat_fe         <= fault_enable;
                        shreg          <= {data_in, {CRC_W{1'b0}}};
                        crc            <= '0;
                        cnt            <= '0;
                    end
                end
                W_CALC: begin
                    crc   <= crc_nxt;
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                W_STORE: begin
                    if (addr_ok)
                        mem[lat_addr] <= {lat_data, crc};
                end
                R_FETCH: begin
                    // Corruption lives only in this copy; the array is never touched.
                    shreg   <= (addr_ok ? mem[lat_addr] : '0) ^ (lat_fe ? fault_mask : '0);
                    rd_data <= (addr_ok ? mem[lat_addr][CW-1:CRC_W] : '0)
                             ^ (lat_fe ? fault_mask[CW-1:CRC_W] : '0);
                    crc     <= '0;
                    cnt     <= '0;
                end
                R_CHECK: begin
                    crc   <= crc_nxt;
                    shreg <= shreg << 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (check_last) begin
                        data_valid     <= 1'b1;
                        error_detected <= check_err;
                        data_out       <= addr_ok ? rd_data : '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CRC_ERR_LOG_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count     <= '0;
            err_last_addr <= '0;
        end else if (check_last && check_err) begin
            if (err_count != 8'hFF)
                err_count <= err_count + 8'd1;
            err_last_addr <= lat_addr;
        end
    end
`endif

endmodule

// File: tb/tb_crc_param_faulty_memory.sv
// tb/tb_crc_param_faulty_memory.sv - directed self-checking bench for crc_param_faulty_memory
module tb_crc_param_faulty_memory;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       write = 1'b0;
    logic       read = 1'b0;
    logic [7:0] data_in = '0;
    logic [3:0] addr_in = '0;
    logic [3:0] fault_addr = '0;
    logic [2:0] burst_error_length = '0;
    logic       fault_enable = 1'b0;

    logic       mem_write_busy, read_busy, data_valid, error_detected, completed;
    logic [7:0] data_out;
    logic       mem_write_busy2, read_busy2, data_valid2, error_detected2, completed2;
    logic [7:0] data_out2;
`ifdef CRC_ERR_LOG_EN
    logic [7:0] err_count, err_count2;
    logic [3:0] err_last_addr, err_last_addr2;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    crc_param_faulty_memory dut (
        .clk(clk), .rst(rst), .write(write), .read(read),
        .data_in(data_in), .addr_in(addr_in), .fault_addr(fault_addr),
        .burst_error_length(burst_error_length), .fault_enable(fault_enable),
        .mem_write_busy(mem_write_busy), .read_busy(read_busy),
        .data_valid(data_valid), .error_detected(error_detected),
        .completed(completed),
`ifdef CRC_ERR_LOG_EN
        .data_out(data_out), .err_count(err_count), .err_last_addr(err_last_addr)
`else
        .data_out(data_out)
`endif
    );

    crc_param_faulty_memory #(.DEPTH(12)) dut2 (
        .clk(clk), .rst(rst), .write(write), .read(read),
        .data_in(data_in), .addr_in(addr_in), .fault_addr(fault_addr),
        .burst_error_length(burst_error_length), .fault_enable(fault_enable),
        .mem_write_busy(mem_write_busy2), .read_busy(read_busy2),
        .data_valid(data_valid2), .error_detected(error_detected2),
        .completed(completed2),
`ifdef CRC_ERR_LOG_EN
        .data_out(data_out2), .err_count(err_count2), .err_last_addr(err_last_addr2)
`else
        .data_out(data_out2)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request, checks the state right after accept, returns edges until completed.
    task automatic do_op(input logic wr, input logic rd, input logic [7:0] d, input logic [3:0] a,
                         input logic fe, input logic [3:0] fa, input logic [2:0] ble, output int lat);
        @(negedge clk);
        write = wr; read = rd; data_in = d; addr_in = a;
        fault_enable = fe; fault_addr = fa; burst_error_length = ble;
        @(posedge clk);
        #1;
        write = 1'b0; read = 1'b0;
        lat = 1;
        @(negedge clk);
        check_eq("accept_wbusy", mem_write_busy, wr);
        check_eq("accept_rbusy", read_busy, !wr && rd);
        check_eq("accept_dv_clr", data_valid, 1'b0);
        while (lat < 60 && !completed) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic wr_op(input logic [7:0] d, input logic [3:0] a);
        int lat;
        do_op(1'b1, 1'b0, d, a, 1'b0, 4'd0, 3'd0, lat);
        check_eq("wr_latency", lat, 10);
    endtask

    task automatic rd_op(input string tag, input logic [3:0] a, input logic fe, input logic [3:0] fa,
                         input logic [2:0] ble, input logic [7:0] exp_d, input logic exp_e);
        int lat;
        do_op(1'b0, 1'b1, 8'h00, a, fe, fa, ble, lat);
        check_eq({tag, "_lat"}, lat, 18);
        check_eq({tag, "_data"}, data_out, exp_d);
        check_eq({tag, "_err"}, error_detected, exp_e);
        check_eq({tag, "_dv"}, data_valid, 1'b1);
    endtask

    logic [7:0] burst_exp [7] = '{8'h4E, 8'h0E, 8'h8E, 8'h8E, 8'h8E, 8'h8E, 8'h8E};

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_outputs", {mem_write_busy, read_busy, data_valid, error_detected, completed}, 5'b0);
        check_eq("rst_data_out", data_out, 8'h00);
        rst = 1'b0;

        wr_op(8'hA5, 4'd0);
        check_eq("crc_field", dut.mem[0], 16'hA572);
        wr_op(8'h3C, 4'd1);
        wr_op(8'h7E, 4'd2);

        rd_op("clean0", 4'd0, 1'b0, 4'd0, 3'd0, 8'hA5, 1'b0);
        rd_op("clean1", 4'd1, 1'b0, 4'd0, 3'd0, 8'h3C, 1'b0);
        rd_op("clean2", 4'd2, 1'b0, 4'd0, 3'd0, 8'h7E, 1'b0);

        repeat (2) @(negedge clk);
        check_eq("held_dv", data_valid, 1'b1);
        check_eq("held_data", data_out, 8'h7E);
        check_eq("completed_pulse", completed, 1'b0);

        rd_op("crc_hit", 4'd1, 1'b1, 4'd3, 3'd0, 8'h3C, 1'b1);
        rd_op("after_hit", 4'd1, 1'b0, 4'd3, 3'd0, 8'h3C, 1'b0);

        for (int b = 1; b <= 7; b++)
            rd_op($sformatf("burst%0d", b + 1), 4'd2, 1'b1, 4'd12, 3'(b), burst_exp[b-1], 1'b1);

        rd_op("trunc", 4'd0, 1'b1, 4'd14, 3'd3, 8'h65, 1'b1);
        rd_op("fe_off", 4'd0, 1'b0, 4'd14, 3'd3, 8'hA5, 1'b0);

        do_op(1'b1, 1'b1, 8'h5A, 4'd4, 1'b0, 4'd0, 3'd0, lat);
        check_eq("both_latency", lat, 10);
        rd_op("both_rd", 4'd4, 1'b0, 4'd0, 3'd0, 8'h5A, 1'b0);

        rd_op("oor15_d16", 4'd15, 1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
        check_eq("oor15_d12_done", completed2, 1'b1);
        check_eq("oor15_d12_data", data_out2, 8'h00);
        check_eq("oor15_d12_err", error_detected2, 1'b1);
        wr_op(8'h7B, 4'd15);
        rd_op("wr15_d16", 4'd15, 1'b0, 4'd0, 3'd0, 8'h7B, 1'b0);
        check_eq("wr15_d12_data", data_out2, 8'h00);
        check_eq("wr15_d12_err", error_detected2, 1'b1);

        @(negedge clk);
        write = 1'b1; data_in = 8'h99; addr_in = 4'd3;
        @(posedge clk);
        #1;
        write = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("wcalc_busy", mem_write_busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_mid_busy", mem_write_busy, 1'b0);
        check_eq("rst_mid_dv", data_valid, 1'b0);
        rst = 1'b0;
        rd_op("aborted3", 4'd3, 1'b0, 4'd0, 3'd0, 8'h00, 1'b0);
        rd_op("cleared0", 4'd0, 1'b0, 4'd0, 3'd0, 8'h00, 1'b0);

        rd_op("log_a", 4'd1, 1'b1, 4'd0, 3'd0, 8'h00, 1'b1);
        rd_op("log_b", 4'd2, 1'b1, 4'd7, 3'd1, 8'h01, 1'b1);
        rd_op("log_c", 4'd5, 1'b1, 4'd15, 3'd0, 8'h80, 1'b1);
`ifdef CRC_ERR_LOG_EN
        check_eq("err_count", err_count, 8'd3);
        check_eq("err_last_addr", err_last_addr, 4'd5);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
